// File: rtl/weight_loader.sv
// Weight memory write front end: filters a broadcast config stream for this neuron's packets.
// Optional trailer checksum is enabled by defining WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader #(
  parameter int numWeight    = 3,
  parameter int neuronNo     = 5,
  parameter int layerNo      = 1,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [31:0]             i_cfg_data,
  input  logic                    i_cfg_valid,
  output logic                    o_cfg_ready,
  input  logic                    i_hold,
  output logic                    o_wen,
  output logic [addressWidth-1:0] o_wadd,
  output logic [dataWidth-1:0]    o_win,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  localparam logic [1:0] HDR  = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SKIP = 2'd2;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam logic [1:0] CSUM = 2'd3;
`endif

  localparam logic [7:0]            LAYER_ID  = 8'(layerNo);
  localparam logic [7:0]            NEURON_ID = 8'(neuronNo);
  localparam logic [addressWidth:0] NUM_W     = (addressWidth + 1)'(numWeight);
  localparam logic [addressWidth:0] IDX_ONE   = (addressWidth + 1)'(1);

  logic [1:0]              r_state;
  logic [15:0]             r_remaining;
  logic [addressWidth:0]   r_index;
  logic                    r_rstnQ;
  logic                    r_wen;
  logic [addressWidth-1:0] r_wadd;
  logic [dataWidth-1:0]    r_win;
  logic                    r_done;
  logic                    r_err;
  logic                    w_accept;
  logic                    w_match;
  logic                    w_lastWord;
  logic [15:0]             w_count;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [31:0]             r_sum;
  logic                    r_pktMatch;
`endif

  // Ready stays low during the reset cycle because it waits on the registered reset.
  assign o_cfg_ready = !i_hold && r_rstnQ;
  assign w_accept    = i_cfg_valid && o_cfg_ready;
  assign w_count     = i_cfg_data[15:0];
  assign w_match     = (i_cfg_data[31:24] == LAYER_ID) && (i_cfg_data[23:16] == NEURON_ID);
  assign w_lastWord  = (r_remaining == 16'd1);

  assign o_wen  = r_wen;
  assign o_wadd = r_wadd;
  assign o_win  = r_win;
  assign o_busy = (r_state != HDR);
  assign o_done = r_done;
  assign o_err  = r_err;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= HDR;
      r_remaining <= '0;
      r_index     <= '0;
      r_rstnQ     <= 1'b0;
      r_wen       <= 1'b0;
      r_wadd      <= '0;
      r_win       <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      r_sum       <= '0;
      r_pktMatch  <= 1'b0;
`endif
    end else begin
      r_rstnQ <= 1'b1;
      r_wen   <= 1'b0;
      if (w_accept) begin
        case (r_state)
          HDR: begin
            r_remaining <= w_count;
            r_index     <= '0;
            if (w_match) begin
              r_done <= 1'b0;
              r_err  <= 1'b0;
            end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            r_sum      <= '0;
            r_pktMatch <= w_match;
            if (w_count == 16'd0) r_state <= CSUM;
            else                  r_state <= w_match ? LOAD : SKIP;
`else
            if (w_count == 16'd0) begin
              r_state <= HDR;
              if (w_match) r_done <= 1'b1;
            end else begin
              r_state <= w_match ? LOAD : SKIP;
            end
`endif
          end
          LOAD: begin
            r_remaining <= r_remaining - 16'd1;
            // Overflow words are discarded rather than wrapped onto earlier addresses.
            if (r_index < NUM_W) begin
              r_wen   <= 1'b1;
              r_wadd  <= r_index[addressWidth-1:0];
              r_win   <= i_cfg_data[dataWidth-1:0];
              r_index <= r_index + IDX_ONE;
            end else begin
              r_err <= 1'b1;
            end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            r_sum <= r_sum + i_cfg_data;
            if (w_lastWord) r_state <= CSUM;
`else
            if (w_lastWord) begin
              r_state <= HDR;
              r_done  <= 1'b1;
            end
`endif
          end
          SKIP: begin
            r_remaining <= r_remaining - 16'd1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            if (w_lastWord) r_state <= CSUM;
`else
            if (w_lastWord) r_state <= HDR;
`endif
          end
          default: begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            // Trailer of a foreign packet is swallowed without touching the flags.
            if (r_pktMatch) begin
              r_done <= 1'b1;
              if (i_cfg_data != r_sum) r_err <= 1'b1;
            end
`endif
            r_state <= HDR;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: stream-level reference model plus literal spot checks.
// Checksum scenarios are compiled in when WEIGHT_LOADER_CHECKSUM_EN is defined.
module tb_weight_loader;

  localparam int NUMW = 3;
  localparam int AW   = 10;
  localparam int DW   = 16;

  logic          clk;
  logic          rstn;
  logic [31:0]   cfgData;
  logic          cfgValid;
  logic          cfgReady;
  logic          hold;
  logic          wen;
  logic [AW-1:0] wadd;
  logic [DW-1:0] win;
  logic          busy;
  logic          done;
  logic          err;

  weight_loader #(
    .numWeight(NUMW), .neuronNo(5), .layerNo(1), .addressWidth(AW), .dataWidth(DW)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_cfg_data(cfgData), .i_cfg_valid(cfgValid),
    .o_cfg_ready(cfgReady), .i_hold(hold), .o_wen(wen), .o_wadd(wadd), .o_win(win),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 0;
  int logAddr[$];
  int logData[$];

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Reference model: parses the accepted word stream packet by packet.
  bit          mRstnPrev   = 0;
  int          mWordsLeft  = 0;
  bit          mTrailerDue = 0;
  bit          mForMe      = 0;
  int          mNextWr     = 0;
  logic [31:0] mSum        = 0;
  bit          expWen      = 0;
  int          expWadd     = 0;
  int          expWin      = 0;
  bit          expDone     = 0;
  bit          expErr      = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    bit accepted;
    accepted = cfgValid && !hold && mRstnPrev;
    expWen   = 0;
    if (!rstn) begin
      mRstnPrev = 0; mWordsLeft = 0; mTrailerDue = 0; mForMe = 0; mNextWr = 0; mSum = 0;
      expWadd = 0; expWin = 0; expDone = 0; expErr = 0;
    end else begin
      mRstnPrev = 1;
      if (accepted) begin
        if (mWordsLeft == 0 && !mTrailerDue) begin
          mForMe     = (cfgData[31:24] == 8'd1) && (cfgData[23:16] == 8'd5);
          mWordsLeft = int'(cfgData[15:0]);
          mNextWr    = 0;
          mSum       = 0;
          if (mForMe) begin expDone = 0; expErr = 0; end
          if (mWordsLeft == 0) begin
            if (CHK) mTrailerDue = 1;
            else if (mForMe) expDone = 1;
          end
        end else if (mWordsLeft > 0) begin
          mWordsLeft--;
          mSum = mSum + cfgData;
          if (mForMe) begin
            if (mNextWr < NUMW) begin
              expWen = 1; expWadd = mNextWr; expWin = int'(cfgData[DW-1:0]);
              mNextWr++;
            end else begin
              expErr = 1;
            end
          end
          if (mWordsLeft == 0) begin
            if (CHK) mTrailerDue = 1;
            else if (mForMe) expDone = 1;
          end
        end else begin
          mTrailerDue = 0;
          if (mForMe) begin
            if (cfgData != mSum) expErr = 1;
            expDone = 1;
          end
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("cfg_ready", int'(cfgReady), int'(!hold && mRstnPrev));
      checkOutput("wen", int'(wen), int'(expWen));
      if (expWen) begin
        checkOutput("wadd", int'(wadd), expWadd);
        checkOutput("win", int'(win), expWin);
      end
      checkOutput("busy", int'(busy), int'((mWordsLeft > 0) || mTrailerDue));
      checkOutput("done", int'(done), int'(expDone));
      checkOutput("err", int'(err), int'(expErr));
      if (wen) begin
        logAddr.push_back(int'(wadd));
        logData.push_back(int'(win));
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] w);
    int waited;
    cfgData  = w;
    cfgValid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (cfgReady) break;
      waited++;
      if (waited > 50) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL handshake_timeout: word 0x%0h not accepted, expected acceptance", w);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyTrailer(input logic [31:0] s);
    if (CHK) applyStimulus(s);
  endtask

  task automatic idle(input int n);
    cfgValid = 1'b0;
    cfgData  = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkLog(input int idx, input int addr, input int data);
    if (idx < logAddr.size()) begin
      checkOutput($sformatf("log%0d_addr", idx), logAddr[idx], addr);
      checkOutput($sformatf("log%0d_data", idx), logData[idx], data);
    end else begin
      checkOutput($sformatf("log%0d_present", idx), logAddr.size(), idx + 1);
    end
  endtask

  task automatic doReset(input int n);
    rstn = 1'b0;
    idle(n);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; hold = 1'b0; cfgValid = 1'b0; cfgData = '0;
    @(posedge clk);
    #1;
    checking = 1;
    idle(2);
    checkOutput("rst_ready", int'(cfgReady), 0);
    checkOutput("rst_done", int'(done), 0);
    rstn = 1'b1;
    idle(1);

    // Basic matching packet
    logAddr.delete(); logData.delete();
    applyStimulus(32'h01050003);
    applyStimulus(32'h00001111);
    applyStimulus(32'h00002222);
    applyStimulus(32'h00003333);
    applyTrailer(32'h00006666);
    idle(2);
    checkOutput("t1_writes", logAddr.size(), 3);
    checkLog(0, 0, 16'h1111); checkLog(1, 1, 16'h2222); checkLog(2, 2, 16'h3333);
    checkOutput("t1_done", int'(done), 1);
    checkOutput("t1_err", int'(err), 0);

    // Foreign packet skipped, then a single-word matching packet
    logAddr.delete(); logData.delete();
    applyStimulus(32'h01060002);
    applyStimulus(32'h0000AAAA);
    applyStimulus(32'h0000BBBB);
    applyTrailer(32'h00016665);
    applyStimulus(32'h01050001);
    applyStimulus(32'h0000ABCD);
    applyTrailer(32'h0000ABCD);
    idle(2);
    checkOutput("t2_writes", logAddr.size(), 1);
    checkLog(0, 0, 16'hABCD);
    checkOutput("t2_done", int'(done), 1);

    // Overflow: five words into a three-word memory
    logAddr.delete(); logData.delete();
    applyStimulus(32'h01050005);
    for (int i = 1; i <= 5; i++) applyStimulus(32'(i));
    applyTrailer(32'd15);
    idle(2);
    checkOutput("t3_writes", logAddr.size(), 3);
    checkLog(0, 0, 1); checkLog(1, 1, 2); checkLog(2, 2, 3);
    checkOutput("t3_err", int'(err), 1);
    checkOutput("t3_done", int'(done), 1);

    // Hold asserted while payload 2 is pending
    logAddr.delete(); logData.delete();
    applyStimulus(32'h01050003);
    applyStimulus(32'h00001111);
    hold = 1'b1; cfgData = 32'h00002222; cfgValid = 1'b1;
    @(negedge clk);
    checkOutput("t4_ready_held", int'(cfgReady), 0);
    repeat (2) @(posedge clk);
    #1;
    hold = 1'b0;
    applyStimulus(32'h00002222);
    applyStimulus(32'h00003333);
    applyTrailer(32'h00006666);
    idle(2);
    checkOutput("t4_writes", logAddr.size(), 3);
    checkLog(0, 0, 16'h1111); checkLog(1, 1, 16'h2222); checkLog(2, 2, 16'h3333);
    checkOutput("t4_err", int'(err), 0);

    // Reset after one payload word abandons the packet
    logAddr.delete(); logData.delete();
    applyStimulus(32'h01050003);
    applyStimulus(32'h00004444);
    cfgValid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_busy", int'(busy), 0);
    checkOutput("t5_done", int'(done), 0);
    checkOutput("t5_ready", int'(cfgReady), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(1);
    applyStimulus(32'h01050001);
    applyStimulus(32'h00005555);
    applyTrailer(32'h00005555);
    idle(2);
    checkOutput("t5_writes", logAddr.size(), 2);
    checkLog(1, 0, 16'h5555);
    checkOutput("t5_done_after", int'(done), 1);

    // Zero-count matching packet sets done with no writes
    doReset(2);
    idle(1);
    logAddr.delete(); logData.delete();
    applyStimulus(32'h01050000);
    applyTrailer(32'h00000000);
    idle(2);
    checkOutput("t6_writes", logAddr.size(), 0);
    checkOutput("t6_done", int'(done), 1);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    applyStimulus(32'h01050002);
    applyStimulus(32'd1);
    applyStimulus(32'd2);
    applyStimulus(32'd3);
    idle(2);
    checkOutput("t7_done", int'(done), 1);
    checkOutput("t7_err", int'(err), 0);
    applyStimulus(32'h01050002);
    applyStimulus(32'd1);
    applyStimulus(32'd2);
    applyStimulus(32'd4);
    idle(2);
    checkOutput("t8_err", int'(err), 1);
    checkOutput("t8_done", int'(done), 1);
`endif

    idle(2);
    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
# weight_loader

Write-side front end for each neuron's weight memory. Consumes a 32-bit configuration word stream carrying tagged weight packets, keeps only packets addressed to its own layer/neuron, and drives the memory write port (wen/wadd/win) with sequential addresses. Packets for other neurons are consumed and dropped, so every neuron in a layer can share one broadcast stream. Sits between the host configuration interface and one weight memory instance per neuron.

## Interface
Parameters:
- numWeight, 3, number of weight words in the target memory
- neuronNo, 5, neuron index this instance accepts
- layerNo, 1, layer index this instance accepts
- addressWidth, 10, memory address width; must satisfy 2^addressWidth >= numWeight
- dataWidth, 16, weight word width (<= 32)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- cfg_data  in  32  stream word (header, payload or checksum)
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  loader accepts word this cycle
- hold  in  1  stall request from neuron (memory being read); blocks acceptance
- wen  out  1  memory write enable
- wadd  out  addressWidth  memory write address
- win  out  dataWidth  memory write data
- busy  out  1  packet in progress (state != HDR)
- done  out  1  sticky: last matching packet fully written
- err  out  1  sticky: overflow or checksum mismatch

## Operation
- Handshake: word accepted when cfg_valid && cfg_ready. cfg_ready = !hold && rstn-registered-high (0 in the reset cycle). Combinational from hold only.
- Header word: [31:24] layer, [23:16] neuron, [15:0] count (payload words following).
- States: HDR, LOAD, SKIP, CSUM (CSUM only with macro).
- HDR: on accepted header, latch count into remaining counter, clear index to 0. Match (layer==layerNo && neuron==neuronNo): clear done and err, go LOAD. No match: go SKIP. count==0: stay HDR (or go CSUM if enabled); matching zero-count packet sets done.
- LOAD: each accepted word decrements remaining. If index < numWeight: write cfg_data[dataWidth-1:0] to address index, index++. If index >= numWeight: word dropped, err set. On last word: go HDR (or CSUM), done set (without macro).
- SKIP: consume count words, no writes, no flag changes; then HDR (or CSUM).
- Index arithmetic: index width addressWidth+1, never wraps; overflow words are discarded, not wrapped to address 0.
- done/err cleared only by reset or next matching header.

## Timing
- Reset values: cfg_ready 0, wen 0, wadd 0, win 0, busy 0, done 0, err 0, state HDR, counters 0.
- Write latency: wen/wadd/win registered; asserted exactly 1 cycle after the accepted payload handshake, for 1 cycle. wen 0 on all other cycles.
- Throughput: one word per cycle when cfg_valid=1 and hold=0; hold=1 freezes state and counters, no acceptance, no writes except one already registered from the prior cycle.
- done rises same edge as the final wen (1 cycle after last handshake).
- Reset asserted mid-packet: return to HDR next edge, partial packet abandoned, memory contents already written are left as-is, done/err cleared.

## Configuration
- WEIGHT_LOADER_CHECKSUM_EN defined: after the count payload words (matching or skipped), one extra trailer word is consumed in CSUM; for matching packets it must equal the 32-bit modulo-2^32 sum of all payload cfg_data words (full 32 bits, including dropped overflow words); mismatch sets err. done set on accepting the trailer (same cycle latency as final write rule: next edge). Skipped packets' trailer consumed without check.
- Not defined: no CSUM state, no trailer; word after last payload is treated as a header.

## Test plan
- Reset, then header 0x01050003 + payloads 0x1111,0x2222,0x3333 back-to-back -> wen pulses at addr 0,1,2 with those data, each 1 cycle after handshake; done=1, err=0.
- Header 0x01060002 + 2 payloads, then matching 0x01050001 + 0xABCD -> no writes for first packet; single write addr 0 = 0xABCD; done=1.
- Header 0x01050005 with numWeight=3 -> writes addr 0..2 only, words 4-5 dropped, err=1, done=1, no write to addr 0 again.
- hold toggled high during payload 2 of 3 -> cfg_ready=0 while hold, payload stays pending, write order and addresses unchanged.
- rstn low after 1 of 3 payloads -> all outputs zero next cycle, next word treated as header.
- With WEIGHT_LOADER_CHECKSUM_EN: payloads 1,2 and trailer 3 -> done=1, err=0; trailer 4 -> err=1.
